keypad_digit_buffer: RTL and testbench

- Latches one-hot keypad scan words into a parametrised bank of 7-segment digit slots, with a write cursor.
- Provides both parallel segment outputs and a time-multiplexed scan output, so one RTL block can drive discrete or multiplexed displays.
- Adds cursor wrap/saturate mode, per-slot written flags, synchronous clear, and illegal-key detection.
- Sits between the keypad scanner and the display pins.

---
 rtl/keypad_digit_buffer.sv | 163 ++++++++++++++++
 tb/tb_keypad_digit_buffer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_digit_buffer.sv
// rtl/keypad_digit_buffer.sv - keypad scan words latched into 7-segment digit slots
// Parallel segment bus plus a free-running time-multiplexed scan output.
module keypad_digit_buffer #(
  parameter int NUM_DIGITS = 8,
  parameter int WRAP       = 1,
  parameter int SCAN_DIV   = 1000,
  parameter int CW         = $clog2(NUM_DIGITS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid,
  input  logic [11:0]             scan_data,
  input  logic                    clr,
  output logic [7*NUM_DIGITS-1:0] seg_bus,
  output logic [6:0]              scan_seg,
  output logic [NUM_DIGITS-1:0]   scan_sel,
  output logic [CW-1:0]           cursor,
  output logic [CW:0]             count,
  output logic                    full,
  output logic                    out_en,
  output logic                    key_err
);

  localparam int              DW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0]   LAST_SLOT  = CW'(NUM_DIGITS - 1);
  localparam logic [DW-1:0]   DIV_LAST   = DW'(SCAN_DIV - 1);
  localparam logic [CW:0]     FULL_COUNT = (CW+1)'(NUM_DIGITS);

  function automatic logic [6:0] f_seg(input int k);
    case (k)
      0:       f_seg = 7'b0111111;
      1:       f_seg = 7'b0000110;
      2:       f_seg = 7'b1011011;
      3:       f_seg = 7'b1001111;
      4:       f_seg = 7'b1100110;
      5:       f_seg = 7'b1101101;
      6:       f_seg = 7'b1111101;
      7:       f_seg = 7'b0000111;
      8:       f_seg = 7'b1111111;
      9:       f_seg = 7'b1101111;
      default: f_seg = 7'b0000000;
    endcase
  endfunction

  logic [6:0]            r_slot [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] r_written;
  logic [CW-1:0]         r_cursor;
  logic [CW:0]           r_count;
  logic                  r_full;
  logic                  r_out_en;
  logic                  r_key_err;
  logic [DW-1:0]         r_div;
  logic [CW-1:0]         r_idx;
  logic [NUM_DIGITS-1:0] r_scan_sel;
  logic [6:0]            r_scan_seg;

  logic [9:0]            w_digits;
  logic                  w_any;
  logic                  w_multi;
  logic                  w_accept;
  logic                  w_write;
  logic                  w_advance;
  logic [6:0]            w_seg_new;
  logic [NUM_DIGITS-1:0] w_written_next;
  logic [CW:0]           w_count_next;
  logic [CW-1:0]         w_cursor_next;
  logic                  w_div_tc;
  logic [DW-1:0]         w_div_next;
  logic [CW-1:0]         w_idx_next;

  assign w_digits  = scan_data[9:0];
  assign w_any     = |w_digits;
  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign w_multi   = (w_digits & (w_digits - 10'd1)) != 10'd0;
  assign w_accept  = valid & ~clr;
  assign w_write   = w_accept & w_any & ~w_multi;
  assign w_advance = w_accept & scan_data[11];

  always_comb begin
    w_seg_new = 7'b0000000;
    for (int k = 0; k < 10; k++) begin
      if (w_digits[k]) w_seg_new = f_seg(k);
    end
  end

  always_comb begin
    w_written_next = r_written;
    if (w_write) w_written_next[r_cursor] = 1'b1;
    w_count_next = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      w_count_next = w_count_next + (CW+1)'(w_written_next[k]);
    end
  end

  always_comb begin
    w_cursor_next = r_cursor;
    if (w_advance) begin
      if (r_cursor == LAST_SLOT) w_cursor_next = (WRAP != 0) ? '0 : r_cursor;
      else                       w_cursor_next = r_cursor + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_DIGITS; k++) r_slot[k] <= 7'b0000000;
      r_written <= '0;
      r_cursor  <= '0;
      r_count   <= '0;
      r_full    <= 1'b0;
      r_out_en  <= 1'b0;
      r_key_err <= 1'b0;
    end else if (clr) begin
      for (int k = 0; k < NUM_DIGITS; k++) r_slot[k] <= 7'b0000000;
      r_written <= '0;
      r_cursor  <= '0;
      r_count   <= '0;
      r_full    <= 1'b0;
      r_out_en  <= 1'b0;
      r_key_err <= 1'b0;
    end else begin
      if (w_write) r_slot[r_cursor] <= w_seg_new;
      r_written <= w_written_next;
      r_count   <= w_count_next;
      r_full    <= (w_count_next == FULL_COUNT);
      r_cursor  <= w_cursor_next;
      if (valid) r_out_en <= scan_data[10];
      r_key_err <= valid & w_multi;
    end
  end

  // Scan select and segments are registered from the next index so they stay aligned.
  assign w_div_tc   = (r_div == DIV_LAST);
  assign w_div_next = w_div_tc ? '0 : r_div + DW'(1);
  assign w_idx_next = !w_div_tc ? r_idx :
                      (r_idx == LAST_SLOT) ? '0 : r_idx + CW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div      <= '0;
      r_idx      <= '0;
      r_scan_sel <= NUM_DIGITS'(1);
      r_scan_seg <= 7'b0000000;
    end else begin
      r_div      <= w_div_next;
      r_idx      <= w_idx_next;
      r_scan_sel <= NUM_DIGITS'(1) << w_idx_next;
      r_scan_seg <= r_slot[w_idx_next];
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_seg_bus
    assign seg_bus[7*g +: 7] = r_slot[g];
  end

  assign scan_seg = r_scan_seg;
  assign scan_sel = r_scan_sel;
  assign cursor   = r_cursor;
  assign count    = r_count;
  assign full     = r_full;
  assign out_en   = r_out_en;
  assign key_err  = r_key_err;

endmodule

// File: tb/tb_keypad_digit_buffer.sv
// tb/tb_keypad_digit_buffer.sv - scoreboard bench for keypad_digit_buffer (wrap and saturate instances)
module tb_keypad_digit_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic        clr = 1'b0;
  logic [11:0] scan_data = 12'h000;

  logic [55:0] seg_w, seg_s;
  logic [6:0]  sseg_w, sseg_s;
  logic [7:0]  sel_w, sel_s;
  logic [2:0]  cur_w, cur_s;
  logic [3:0]  cnt_w, cnt_s;
  logic        full_w, full_s, oe_w, oe_s, ke_w, ke_s;

  keypad_digit_buffer #(.NUM_DIGITS(8), .WRAP(1), .SCAN_DIV(4)) u_wrap (
    .clk(clk), .rst(rst), .valid(valid), .scan_data(scan_data), .clr(clr),
    .seg_bus(seg_w), .scan_seg(sseg_w), .scan_sel(sel_w), .cursor(cur_w),
    .count(cnt_w), .full(full_w), .out_en(oe_w), .key_err(ke_w));

  keypad_digit_buffer #(.NUM_DIGITS(8), .WRAP(0), .SCAN_DIV(4)) u_sat (
    .clk(clk), .rst(rst), .valid(valid), .scan_data(scan_data), .clr(clr),
    .seg_bus(seg_s), .scan_seg(sseg_s), .scan_sel(sel_s), .cursor(cur_s),
    .count(cnt_s), .full(full_s), .out_en(oe_s), .key_err(ke_s));

  always #5 clk = ~clk;

  typedef struct {
    logic [55:0] seg;
    logic [2:0]  cw;
    logic [2:0]  cs;
    logic [3:0]  cnt;
    logic        full;
    logic        oe;
    logic        ke;
    logic        scan;
    logic [7:0]  sel;
    logic [6:0]  sseg;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   ecnt;
  logic chk = 1'b0, chk_q = 1'b0, probe = 1'b0;

  logic [6:0] m_slot [8];
  logic [7:0] m_wr;
  logic [2:0] m_cw, m_cs;
  logic       m_oe, m_ke;

  always @(posedge clk or posedge rst) begin
    if (rst) ecnt <= 0;
    else     ecnt <= ecnt + 1;
  end

  always @(posedge clk) chk_q <= chk;

  function automatic logic [6:0] seg_of(input int k);
    case (k)
      0: return 7'b0111111;  1: return 7'b0000110;
      2: return 7'b1011011;  3: return 7'b1001111;
      4: return 7'b1100110;  5: return 7'b1101101;
      6: return 7'b1111101;  7: return 7'b0000111;
      8: return 7'b1111111;  9: return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 8; k++) m_slot[k] = 7'b0;
    m_wr = 8'h00; m_cw = 3'd0; m_cs = 3'd0; m_oe = 1'b0; m_ke = 1'b0;
  endtask

  task automatic model_apply(input logic v, input logic [11:0] d, input logic c);
    logic [9:0] dig;
    dig = d[9:0];
    if (c) begin
      model_reset();
    end else if (v) begin
      m_ke = ($countones(dig) > 1);
      if ($countones(dig) == 1) begin
        for (int k = 0; k < 10; k++) if (dig[k]) m_slot[m_cw] = seg_of(k);
        m_wr[m_cw] = 1'b1;
      end
      m_oe = d[10];
      if (d[11]) begin
        m_cw = (m_cw == 3'd7) ? 3'd0 : m_cw + 3'd1;
        m_cs = (m_cs == 3'd7) ? 3'd7 : m_cs + 3'd1;
      end
    end else begin
      m_ke = 1'b0;
    end
  endtask

  function automatic exp_t snap(input logic scan, input int idx);
    exp_t e;
    for (int k = 0; k < 8; k++) e.seg[7*k +: 7] = m_slot[k];
    e.cw   = m_cw;
    e.cs   = m_cs;
    e.cnt  = 4'($countones(m_wr));
    e.full = (m_wr == 8'hFF);
    e.oe   = m_oe;
    e.ke   = m_ke;
    e.scan = scan;
    e.sel  = 8'h01 << idx;
    e.sseg = m_slot[idx];
    return e;
  endfunction

  task automatic check(input string tag, input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s.%s actual=%0h required=%0h", tag, name, act, exp);
    end
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s.queue_underflow actual=0 required=1", tag);
      return;
    end
    e = q.pop_front();
    check(tag, "seg_bus_w", seg_w, e.seg);
    check(tag, "seg_bus_s", seg_s, e.seg);
    check(tag, "cursor_w", cur_w, e.cw);
    check(tag, "cursor_s", cur_s, e.cs);
    check(tag, "count_w", cnt_w, e.cnt);
    check(tag, "count_s", cnt_s, e.cnt);
    check(tag, "full_w", full_w, e.full);
    check(tag, "full_s", full_s, e.full);
    check(tag, "out_en", {oe_w, oe_s}, {e.oe, e.oe});
    check(tag, "key_err", {ke_w, ke_s}, {e.ke, e.ke});
    if (e.scan) begin
      check(tag, "scan_sel", {sel_w, sel_s}, {e.sel, e.sel});
      check(tag, "scan_seg", {sseg_w, sseg_s}, {e.sseg, e.sseg});
    end
  endtask

  always @(negedge clk) if (chk_q) pop_check("cyc");
  always @(posedge probe) pop_check("async");

  task automatic drive(input logic v, input logic [11:0] d, input logic c, input logic scan);
    @(posedge clk);
    #1;
    valid = v; scan_data = d; clr = c; chk = 1'b1;
    model_apply(v, d, c);
    q.push_back(snap(scan, ((ecnt + 1) / 4) % 8));
  endtask

  task automatic quiet(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      valid = 1'b0; scan_data = 12'h000; clr = 1'b0; chk = 1'b0;
      model_apply(1'b0, 12'h000, 1'b0);
    end
  endtask

  task automatic async_reset_probe();
    model_reset();
    q.push_back(snap(1'b1, 0));
    probe = 1'b1;
    #1 probe = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    model_reset();
    #12;
    async_reset_probe();
    @(negedge clk);
    rst = 1'b0;

    drive(1'b1, 12'h004, 1'b0, 1'b0);
    drive(1'b0, 12'h000, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) drive(1'b1, 12'h800 | 12'(1 << k), 1'b0, 1'b0);
    drive(1'b1, 12'h800, 1'b0, 1'b0);
    drive(1'b1, 12'h403, 1'b0, 1'b0);
    drive(1'b0, 12'h000, 1'b0, 1'b0);
    drive(1'b1, 12'h809, 1'b1, 1'b0);

    for (int k = 0; k < 8; k++) drive(1'b1, 12'h800 | 12'(1 << (k + 1)), 1'b0, 1'b0);
    quiet(2);
    repeat (40) drive(1'b0, 12'h000, 1'b0, 1'b1);
    drive(1'b1, 12'h400, 1'b0, 1'b0);
    quiet(1);

    @(posedge clk);
    #3 rst = 1'b1;
    #1 async_reset_probe();
    @(negedge clk);
    rst = 1'b0;

    drive(1'b1, 12'h010, 1'b0, 1'b0);
    drive(1'b1, 12'h820, 1'b0, 1'b0);
    drive(1'b1, 12'h000, 1'b0, 1'b0);
    quiet(2);

    check("end", "queue_drained", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
